// File: rtl/result_capture.sv
// Capture buffer behind the rank-order filter: drops the pipeline-fill samples, stores the next
// DEPTH results, and exposes a button-stepped read port for the seven-segment display.
module result_capture #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int SKIP      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 step_up,
  input  logic                 step_down,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 overflow
);

  localparam int                   SKIP_BITS = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
  localparam logic [ADDR_BITS:0]   DEPTH_C   = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_C    = ADDR_BITS'(DEPTH - 1);
  localparam logic [SKIP_BITS-1:0] SKIP_C    = SKIP_BITS'(SKIP);

  typedef enum logic [1:0] {
    ST_SKIP,
    ST_CAPTURE,
    ST_FULL
  } state_t;

  localparam state_t RESET_STATE = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;

  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [SKIP_BITS-1:0] skip_cnt_q, skip_cnt_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 full_q, full_d;
  logic                 overflow_q, overflow_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 step_up_q, step_down_q;
  logic                 mem_we;
  logic                 up_rise, down_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RESET_STATE;
      skip_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      // Held buttons must not register as a fresh press once reset releases.
      step_up_q   <= 1'b1;
      step_down_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= ({1'b0, rd_addr_q} < count_q) ? mem[rd_addr_q] : '0;
      step_up_q   <= step_up;
      step_down_q <= step_down;
    end
  end

  // Memory is deliberately never cleared; stale contents are hidden by count.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    rd_addr_d  = rd_addr_q;
    mem_we     = 1'b0;
    up_rise    = step_up & ~step_up_q;
    down_rise  = step_down & ~step_down_q;

    case (state_q)
      ST_SKIP: begin
        if (in_valid) begin
          skip_cnt_d = skip_cnt_q + SKIP_BITS'(1);
          if (skip_cnt_d == SKIP_C) begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (in_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + ADDR_BITS'(1);
          count_d  = count_q + (ADDR_BITS + 1)'(1);
          if (count_d == DEPTH_C) begin
            state_d = ST_FULL;
            full_d  = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (in_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    if (up_rise && !down_rise) begin
      rd_addr_d = (rd_addr_q == LAST_C) ? '0 : rd_addr_q + ADDR_BITS'(1);
    end else if (down_rise && !up_rise) begin
      rd_addr_d = (rd_addr_q == '0) ? LAST_C : rd_addr_q - ADDR_BITS'(1);
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: doc/result_capture.md
Name: result_capture

Overview:
- Downstream stage of the adaptive rank-order filter; replaces the ad-hoc output RAM.
- Discards the filter's pipeline-fill outputs.
- Captures the next DEPTH valid results into an internal buffer.
- Provides a stepped read-out port driven by debounced buttons, for seven-segment display of address and data.

Parameters:
DATA_BITS, 8, width of filter output samples
DEPTH, 256, number of capture locations
ADDR_BITS, $clog2(DEPTH), read/write address width
SKIP, 2, number of initial valid samples discarded (filter fill latency)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
in_valid  in  1  filter output sample valid this cycle
in_data  in  DATA_BITS  filter output sample
step_up  in  1  debounced level; rising edge advances read address
step_down  in  1  debounced level; rising edge decrements read address
rd_addr  out  ADDR_BITS  current read address
rd_data  out  DATA_BITS  registered buffer contents at rd_addr
count  out  ADDR_BITS+1  number of samples captured
full  out  1  count == DEPTH
overflow  out  1  sticky; valid sample arrived while full

Behaviour:
- Reset (rst=0 at a clk edge) forces the following:
  - state=SKIP, skip_cnt=0, wr_ptr=0, count=0.
  - rd_addr=0, rd_data=0, full=0, overflow=0.
  - step edge registers set to 1, so a button held through reset does not step.
- Buffer memory is not cleared. Any read with rd_addr >= count returns 0.
- Write FSM:
  - SKIP: each in_valid increments skip_cnt and discards the sample. When skip_cnt reaches SKIP, go to CAPTURE. If SKIP=0, reset enters CAPTURE directly.
  - CAPTURE: on each in_valid, mem[wr_ptr]<=in_data, wr_ptr++, count++. When count reaches DEPTH, go to FULL and set full=1 in the same cycle count becomes DEPTH. wr_ptr wraps to 0 but is unused afterwards.
  - FULL: in_valid is ignored, memory and count are unchanged, overflow<=1 (sticky until reset). No exit except reset.
- in_valid=0 in any state: no state change. Gaps of any length are allowed.
- Read side:
  - up_rise = step_up & ~step_up_q; down_rise = step_down & ~step_down_q. The _q registers update every cycle.
  - up_rise only: rd_addr <= rd_addr+1 mod DEPTH (DEPTH-1 wraps to 0).
  - down_rise only: rd_addr <= rd_addr-1 mod DEPTH (0 wraps to DEPTH-1).
  - Both rises in the same cycle: rd_addr unchanged.
  - A level held high produces exactly one step.
- rd_data latency:
  - rd_data <= (rd_addr < count) ? mem[rd_addr] : 0, registered every cycle.
  - rd_data therefore reflects the rd_addr and count of the previous cycle, one cycle behind an address change.
- Read and write of the same address in the same cycle: that address is >= count before the write, so rd_data=0 that cycle and shows the new data one cycle later.
- Reset mid-capture: all state returns to reset values on that edge. Skipping restarts. Old memory contents are masked by count=0.
- Widths:
  - count is ADDR_BITS+1 so it can hold DEPTH.
  - Compare rd_addr zero-extended against count.
  - No arithmetic exceeds these widths.

Test Plan:
1. Reset, SKIP=2, DEPTH=256; drive in_valid with in_data 10,20,30,40,50 (gaps of 1 idle cycle) -> count=3, full=0; step_up sequence shows mem[0..2]=30,40,50 (0x1E,0x28,0x32).
2. After test 1 at rd_addr=0, pulse step_up 3 times -> rd_addr=1,2,3; rd_data one cycle later =40,50,0 (addr 3 unwritten, masked).
3. From rd_addr=0, pulse step_down once -> rd_addr=255, rd_data=0; step_up once -> rd_addr=0, rd_data=30.
4. DEPTH=4, SKIP=0; feed 1,2,3,4,5,6 -> full=1 in the cycle the 4th is written, count=4; overflow=1 after the 5th; addresses 0..3 read 1,2,3,4.
5. step_up and step_down rise in the same cycle -> rd_addr unchanged. step_up held high for 10 cycles -> single increment. Buttons held high across reset release -> no step.
6. Assert rst=0 for one cycle after 2 captured samples -> next cycle count=0, rd_addr=0, rd_data=0, full=0, overflow=0; the next 2 valid samples are skipped again.
